// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared defaults and length helpers for the serial pattern detector
package seq_det_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 16;

    // Lengths of 0 become 1 and anything above max becomes max.
    function automatic int clamp_len(input int len, input int max);
        return (len < 1) ? 1 : (len > max) ? max : len;
    endfunction

    // The result has the low len bits set; callers truncate it to their own width.
    function automatic logic [63:0] len_mask(input int len);
        return (len >= 64) ? '1 : (64'(1) << len) - 64'(1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up counter that stops at all-ones, with synchronous reset and clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    // Count up on inc and stop at the top value; reset and clr both zero the count.
    always_ff @(posedge clk)
        if (reset || clr) q <= '0;
        else if (inc && q != '1) q <= q + W'(1);

endmodule

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: programmable serial pattern detector with overlap mode and hit counter
// The optional hit_sticky output is present only when SEQ_DET_STICKY_EN is defined.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               hit,
    output logic [CNT_W-1:0]   hit_count
`ifdef SEQ_DET_STICKY_EN
    ,
    output logic               hit_sticky
`endif
);

    logic [MAX_LEN-1:0] pat_q, hist, hist_n, mask;
    logic [LEN_W-1:0]   len_q, fill, fill_n;
    logic               ovl_q, restart, accept, match;

    assign restart = reset || clear;
    assign accept  = in_valid && !restart;

    // Work out the next shift-register value and fill level, then compare under the length mask.
    always_comb begin
        hist_n = {hist[MAX_LEN-2:0], in_bit};
        fill_n = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
        mask   = MAX_LEN'(len_mask(int'(len_q)));
        match  = accept && (fill_n >= len_q) && (((hist_n ^ pat_q) & mask) == '0);
    end

    // Configuration is captured only on reset or clear, so it cannot change in the middle of a search.
    always_ff @(posedge clk)
        if (restart) begin
            pat_q <= cfg_pattern;
            len_q <= LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
            ovl_q <= cfg_overlap;
        end

    // Shift in accepted bits; without overlap, the fill level restarts after each hit.
    always_ff @(posedge clk)
        if (restart) begin
            hist <= '0;
            fill <= '0;
            hit  <= 1'b0;
        end else begin
            hit <= match;
            if (accept) begin
                hist <= hist_n;
                fill <= (match && !ovl_q) ? '0 : fill_n;
            end
        end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (clear),
        .inc  (match),
        .q    (hit_count)
    );

`ifdef SEQ_DET_STICKY_EN
    // The sticky flag latches the first hit and stays set until reset or clear.
    always_ff @(posedge clk)
        if (restart) hit_sticky <= 1'b0;
        else if (match) hit_sticky <= 1'b1;
`endif

endmodule
